// File: rtl/axi_cnt_pkg.sv
// rtl/axi_cnt_pkg.sv - shared types and register map constants for the counter engine
package axi_cnt_pkg;

  // Counter FSM encoding; value 3 is never produced and decodes back to IDLE
  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_e;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_DIR_BIT     = 1;
  localparam int unsigned CTRL_ONESHOT_BIT = 2;

  // Register byte offsets inside the slave window
  localparam logic [7:0] REG_CTRL_OFS   = 8'h00;
  localparam logic [7:0] REG_LOAD_OFS   = 8'h04;
  localparam logic [7:0] REG_PERIOD_OFS = 8'h08;
  localparam logic [7:0] REG_CMP_OFS    = 8'h0C;
  localparam logic [7:0] REG_CNT_OFS    = 8'h10;
  localparam logic [7:0] REG_STATUS_OFS = 8'h14;

  // STATUS register bit positions
  localparam int unsigned STATUS_TC_BIT  = 0;
  localparam int unsigned STATUS_CMP_BIT = 1;
  localparam int unsigned STATUS_IRQ_BIT = 2;

  // Assemble the STATUS read-back word from the engine's flag outputs
  function automatic logic [31:0] status_word(input logic tc, input logic cmp, input logic irq);
    logic [31:0] w;
    w = '0;
    w[STATUS_TC_BIT]  = tc;
    w[STATUS_CMP_BIT] = cmp;
    w[STATUS_IRQ_BIT] = irq;
    return w;
  endfunction

endpackage

// File: rtl/axi_cnt_presc.sv
// rtl/axi_cnt_presc.sv - tick prescaler, built only when CNT_PRESCALE_EN is defined
`ifdef CNT_PRESCALE_EN
module axi_cnt_presc #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pre_q;

  // A tick fires on the clk where the phase reaches the divider value
  assign tick_o = en_i && (pre_q == presc_i);

  // Phase counter: cleared by a load, frozen whenever the engine is not running
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pre_q <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
    end else if (en_i) begin
      pre_q <= tick_o ? '0 : pre_q + PRESC_W'(1);
    end
  end

endmodule
`endif

// File: rtl/axi_cnt_core.sv
// rtl/axi_cnt_core.sv - counter engine behind the register block; CNT_PRESCALE_EN adds a tick prescaler
module axi_cnt_core
  import axi_cnt_pkg::*;
#(
  parameter int unsigned CNT_W = 32
`ifdef CNT_PRESCALE_EN
  ,
  parameter int unsigned PRESC_W = 16
`endif
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic               oneshot_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   load_val_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   cmp_i,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_i,
`endif
  input  logic               irq_ack_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [1:0]         state_o,
  output logic               tc_flag_o,
  output logic               cmp_flag_o,
  output logic               irq_o
);

  cnt_state_e       state_q, state_d;
  logic             run_active;
  logic             tick;
  logic             tick_eff;
  logic             at_term;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_tick_val;
  logic             tc_set, cmp_set;
  logic             tc_q, tc_d;
  logic             cmp_q, cmp_d;
  logic             irq_q;

`ifdef CNT_PRESCALE_EN
  axi_cnt_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .areset  (areset),
    .en_i    (run_active),
    .clr_i   (load_i),
    .presc_i (presc_i),
    .tick_o  (tick)
  );
`else
  assign tick = run_active;
`endif

  // State register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= CNT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a load beats a terminal tick, so a oneshot never stops on a load cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_IDLE: begin
        if (en_i) state_d = CNT_RUN;
      end
      CNT_RUN: begin
        if (!en_i) begin
          state_d = CNT_IDLE;
        end else if (tick_eff && at_term && oneshot_i) begin
          state_d = CNT_DONE;
        end
      end
      CNT_DONE: begin
        if (!en_i || load_i) state_d = CNT_IDLE;
      end
      default: begin
        state_d = CNT_IDLE;
      end
    endcase
  end

  // FSM outputs: counting only while RUN with enable still high, so a dropped enable holds the count
  always_comb begin
    run_active = (state_q == CNT_RUN) && en_i;
    state_o    = state_q;
  end

  // Count datapath: terminal detection, wrap/reload/hold, then load override
  always_comb begin
    at_term  = dir_i ? (cnt_q == '0) : (cnt_q == period_i);
    tick_eff = tick && !load_i;
    if (!dir_i) begin
      if (at_term) begin
        cnt_tick_val = oneshot_i ? cnt_q : '0;
      end else begin
        cnt_tick_val = cnt_q + CNT_W'(1);
      end
    end else begin
      if (at_term) begin
        cnt_tick_val = oneshot_i ? cnt_q : period_i;
      end else begin
        cnt_tick_val = cnt_q - CNT_W'(1);
      end
    end
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick) begin
      cnt_d = cnt_tick_val;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky flags: only a real tick sets them, and a set beats a same-cycle ack
  always_comb begin
    tc_set  = tick_eff && at_term;
    cmp_set = tick_eff && (cnt_tick_val == cmp_i);
    tc_d    = tc_set  | (tc_q  & ~irq_ack_i);
    cmp_d   = cmp_set | (cmp_q & ~irq_ack_i);
  end

  // Count, flag and interrupt registers; irq samples next-state flags so it rises with them
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      cmp_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      cmp_q <= cmp_d;
      irq_q <= tc_d | cmp_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign tc_flag_o  = tc_q;
  assign cmp_flag_o = cmp_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_axi_cnt_core.sv
// tb/tb_axi_cnt_core.sv - self-checking bench for axi_cnt_core with a behavioural reference model
module tb_axi_cnt_core;

  localparam int CNT_W = 8;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             areset = 1'b0;
  logic             en_i = 1'b0;
  logic             dir_i = 1'b0;
  logic             oneshot_i = 1'b0;
  logic             load_i = 1'b0;
  logic [CNT_W-1:0] load_val_i = '0;
  logic [CNT_W-1:0] period_i = '0;
  logic [CNT_W-1:0] cmp_i = '0;
  logic             irq_ack_i = 1'b0;
`ifdef CNT_PRESCALE_EN
  localparam int PRESC_W = 16;
  logic [PRESC_W-1:0] presc_i = '0;
`endif
  logic [CNT_W-1:0] cnt_o;
  logic [1:0]       state_o;
  logic             tc_flag_o, cmp_flag_o, irq_o;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  axi_cnt_core #(
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .oneshot_i  (oneshot_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .period_i   (period_i),
    .cmp_i      (cmp_i),
`ifdef CNT_PRESCALE_EN
    .presc_i    (presc_i),
`endif
    .irq_ack_i  (irq_ack_i),
    .cnt_o      (cnt_o),
    .state_o    (state_o),
    .tc_flag_o  (tc_flag_o),
    .cmp_flag_o (cmp_flag_o),
    .irq_o      (irq_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 stopped after a oneshot
  int m_cnt = 0;
  int m_mode = 0;
  int m_pre = 0;
  bit m_tc = 1'b0;
  bit m_cf = 1'b0;
  bit m_irq = 1'b0;

  always @(posedge clk or negedge areset) begin
    int nxt;
    int nmode;
    bit counting, tk, hit_tc, hit_cmp;
    if (!areset) begin
      m_cnt = 0; m_mode = 0; m_pre = 0; m_tc = 0; m_cf = 0; m_irq = 0;
    end else begin
      counting = (m_mode == 1) && en_i;
`ifdef CNT_PRESCALE_EN
      tk = counting && (m_pre == int'(presc_i));
`else
      tk = counting;
`endif
      nxt = m_cnt; nmode = m_mode; hit_tc = 0; hit_cmp = 0;
      if (load_i) begin
        nxt = int'(load_val_i);
      end else if (tk) begin
        if (!dir_i) begin
          if (m_cnt == int'(period_i)) begin
            hit_tc = 1;
            nxt = oneshot_i ? m_cnt : 0;
          end else begin
            nxt = (m_cnt + 1) & MASK;
          end
        end else begin
          if (m_cnt == 0) begin
            hit_tc = 1;
            nxt = oneshot_i ? 0 : int'(period_i);
          end else begin
            nxt = m_cnt - 1;
          end
        end
        hit_cmp = (nxt == int'(cmp_i));
      end
      if (m_mode == 0) begin
        if (en_i) nmode = 1;
      end else if (m_mode == 1) begin
        if (!en_i) nmode = 0;
        else if (hit_tc && oneshot_i) nmode = 2;
      end else begin
        if (!en_i || load_i) nmode = 0;
      end
      if (load_i) m_pre = 0;
      else if (counting) m_pre = tk ? 0 : (m_pre + 1) & 16'hFFFF;
      m_cnt  = nxt;
      m_mode = nmode;
      m_tc   = hit_tc  || (m_tc && !irq_ack_i);
      m_cf   = hit_cmp || (m_cf && !irq_ack_i);
      m_irq  = m_tc || m_cf;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_cnt", 32'(cnt_o), 32'(m_cnt));
      chk("cyc_state", 32'(state_o), 32'(m_mode));
      chk("cyc_tc", 32'(tc_flag_o), 32'(m_tc));
      chk("cyc_cmp", 32'(cmp_flag_o), 32'(m_cf));
      chk("cyc_irq", 32'(irq_o), 32'(m_irq));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input int v);
    load_val_i = CNT_W'(v);
    load_i = 1'b1;
    cyc();
    load_i = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1;
    cyc();
    irq_ack_i = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (int'(cnt_o) != v && n < 400) begin
      cyc();
      n++;
    end
    chk("wait_cnt", 32'(cnt_o), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_seq[6];
    up_seq = '{1, 2, 3, 4, 5, 0};
    cmp_on = 1'b1;

    // Reset values
    repeat (3) cyc();
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_tc", 32'(tc_flag_o), 0);
    chk("rst_cmp", 32'(cmp_flag_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    areset = 1'b1;

    // Up count 0..5 with wrap
    dir_i = 0; oneshot_i = 0; period_i = 5; cmp_i = 200; en_i = 1;
    cyc();
    chk("up_state_run", 32'(state_o), 1);
    chk("up_first", 32'(cnt_o), 0);
    foreach (up_seq[i]) begin
      if (up_seq[i] == 0) chk("up_tc_before_wrap", 32'(tc_flag_o), 0);
      cyc();
      chk("up_seq", 32'(cnt_o), 32'(up_seq[i]));
    end
    chk("up_wrap_tc", 32'(tc_flag_o), 1);
    chk("up_wrap_irq", 32'(irq_o), 1);
    chk("up_wrap_state", 32'(state_o), 1);
    en_i = 0;
    cyc();
    chk("up_stop_state", 32'(state_o), 0);
    chk("up_stop_hold", 32'(cnt_o), 0);
    pulse_ack();
    chk("up_ack_tc", 32'(tc_flag_o), 0);
    chk("up_ack_irq", 32'(irq_o), 0);

    // Down oneshot from 3
    dir_i = 1; oneshot_i = 1; period_i = 5;
    pulse_load(3);
    chk("dn_load", 32'(cnt_o), 3);
    en_i = 1;
    cyc();
    chk("dn_run", 32'(state_o), 1);
    for (int v = 2; v >= 0; v--) begin
      cyc();
      chk("dn_seq", 32'(cnt_o), 32'(v));
    end
    cyc();
    chk("dn_done_state", 32'(state_o), 2);
    chk("dn_done_cnt", 32'(cnt_o), 0);
    chk("dn_done_tc", 32'(tc_flag_o), 1);
    cyc();
    chk("dn_done_hold", 32'(cnt_o), 0);
    chk("dn_done_stay", 32'(state_o), 2);
    en_i = 0;
    cyc();
    chk("dn_idle", 32'(state_o), 0);

    // Compare flag, ack, and set-beats-ack
    pulse_ack();
    dir_i = 0; oneshot_i = 0; period_i = 10; cmp_i = 7;
    pulse_load(0);
    en_i = 1;
    cyc();
    repeat (6) cyc();
    chk("cmp_pre", 32'(cmp_flag_o), 0);
    cyc();
    chk("cmp_cnt7", 32'(cnt_o), 7);
    chk("cmp_set", 32'(cmp_flag_o), 1);
    chk("cmp_irq", 32'(irq_o), 1);
    pulse_ack();
    chk("cmp_cleared", 32'(cmp_flag_o), 0);
    chk("cmp_irq_cleared", 32'(irq_o), 0);
    wait_cnt(6);
    pulse_ack();
    chk("cmp_set_wins", 32'(cmp_flag_o), 1);
    chk("cmp_tc_acked", 32'(tc_flag_o), 0);
    chk("cmp_irq_kept", 32'(irq_o), 1);

    // Load beats tick, lands on cmp without setting it, out-of-range continues
    en_i = 0;
    cyc();
    pulse_ack();
    period_i = 8'h10; cmp_i = 8'h20; en_i = 1;
    cyc();
    pulse_load(8'h20);
    chk("ld_val", 32'(cnt_o), 32'h20);
    chk("ld_no_cmp", 32'(cmp_flag_o), 0);
    chk("ld_no_tc", 32'(tc_flag_o), 0);
    cyc();
    chk("ld_next", 32'(cnt_o), 32'h21);

    // Asynchronous reset mid-run
    period_i = 20;
    pulse_load(0);
    wait_cnt(9);
    #2 areset = 0;
    #1;
    chk("ar_cnt", 32'(cnt_o), 0);
    chk("ar_state", 32'(state_o), 0);
    chk("ar_tc", 32'(tc_flag_o), 0);
    chk("ar_cmp", 32'(cmp_flag_o), 0);
    chk("ar_irq", 32'(irq_o), 0);
    cyc();
    areset = 1;

    // Zero period: holds 0, terminal every tick in both directions
    period_i = 0; dir_i = 0; oneshot_i = 0; cmp_i = 200;
    cyc();
    cyc();
    chk("p0_up_cnt", 32'(cnt_o), 0);
    chk("p0_up_tc", 32'(tc_flag_o), 1);
    pulse_ack();
    chk("p0_ack_set_wins", 32'(tc_flag_o), 1);
    dir_i = 1;
    cyc();
    chk("p0_dn_cnt", 32'(cnt_o), 0);

`ifdef CNT_PRESCALE_EN
    // Prescaler divide-by-3 and phase clear on load
    presc_i = 2; dir_i = 0; period_i = 100; cmp_i = 200;
    pulse_load(0);
    cyc();
    cyc();
    chk("ps_hold", 32'(cnt_o), 0);
    cyc();
    chk("ps_tick1", 32'(cnt_o), 1);
    repeat (3) cyc();
    chk("ps_tick2", 32'(cnt_o), 2);
    cyc();
    pulse_load(8'h40);
    cyc();
    cyc();
    chk("ps_ld_hold", 32'(cnt_o), 32'h40);
    cyc();
    chk("ps_ld_tick", 32'(cnt_o), 32'h41);
`endif

    // Randomized run checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      en_i = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 19) == 0) dir_i = 1'($urandom);
      if ($urandom_range(0, 19) == 0) oneshot_i = ($urandom_range(0, 3) == 0);
      load_i = ($urandom_range(0, 24) == 0);
      load_val_i = CNT_W'($urandom_range(0, 255));
      irq_ack_i = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) period_i = CNT_W'($urandom);
        else period_i = CNT_W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 29) == 0) cmp_i = CNT_W'($urandom_range(0, 12));
`ifdef CNT_PRESCALE_EN
      if ($urandom_range(0, 49) == 0) presc_i = PRESC_W'($urandom_range(0, 3));
`endif
      if (i == 1500) begin
        #2 areset = 0;
        cyc();
        areset = 1;
      end else begin
        cyc();
      end
    end

    load_i = 0;
    irq_ack_i = 0;
    cyc();
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
